// File: rtl/class_hv_assembler_if.sv
// Handshake bundle for the class-HV assembler.
//   chunk side : chunk_valid/chunk_ready/chunk_in, plus chunk_idx (next slot)
//   vector side: hv_valid/hv_ready/hv_out (complete hypervector)
// master = upstream chunk producer + downstream class memory; slave = assembler.
interface class_hv_assembler_if #(
  parameter int HV_DIM      = 4096,
  parameter int DIMS_PER_CC = 1024
);
  localparam int NUM_CHUNKS = HV_DIM / DIMS_PER_CC;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  logic                   chunk_valid;
  logic                   chunk_ready;
  logic [DIMS_PER_CC-1:0] chunk_in;
  logic [IDX_W-1:0]       chunk_idx;
  logic                   hv_valid;
  logic                   hv_ready;
  logic [HV_DIM-1:0]      hv_out;

  modport master (
    output chunk_valid, chunk_in, hv_ready,
    input  chunk_ready, chunk_idx, hv_valid, hv_out
  );

  modport slave (
    input  chunk_valid, chunk_in, hv_ready,
    output chunk_ready, chunk_idx, hv_valid, hv_out
  );
endinterface

// File: rtl/class_hv_assembler.sv
// Reassembles a full class hypervector from DIMS_PER_CC-wide chunks.
// Chunk k lands in hv_out[k*DIMS_PER_CC +: DIMS_PER_CC]; once the last slot is
// written the vector is held (hv_valid) until the class memory takes it.
// Ports:
//   clk   - clock, rising edge
//   nrst  - asynchronous active-low reset
//   clear - synchronous abort, overrides every handshake in the same cycle
//   bus   - class_hv_assembler_if.slave (chunk and vector handshakes)
// All outputs come straight from registers; HV_DIM must be a multiple of
// DIMS_PER_CC.
module class_hv_assembler #(
  parameter int HV_DIM      = 4096,
  parameter int DIMS_PER_CC = 1024
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  class_hv_assembler_if.slave   bus
);
  localparam int NUM_CHUNKS = HV_DIM / DIMS_PER_CC;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ctr_q, ctr_d;
  logic [HV_DIM-1:0] hv_w;
  logic              accept;

  // clear voids a chunk offered in the same cycle
  assign accept = bus.chunk_valid && (state_q == FILL) && !clear;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FILL;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    if (clear) begin
      state_d = FILL;
      ctr_d   = '0;
    end else begin
      case (state_q)
        FILL: if (accept) begin
          if (ctr_q == LAST) begin
            ctr_d   = '0;
            state_d = HOLD;
          end else begin
            ctr_d = ctr_q + 1'b1;
          end
        end
        HOLD: if (bus.hv_ready) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  // One register per slot; only the slot addressed by ctr_q is written.
  // Stale slots are simply overwritten by the next vector.
  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_slot
    logic [DIMS_PER_CC-1:0] slot_q;
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                               slot_q <= '0;
      else if (clear)                          slot_q <= '0;
      else if (accept && ctr_q == IDX_W'(g))   slot_q <= bus.chunk_in;
    end
    assign hv_w[g*DIMS_PER_CC +: DIMS_PER_CC] = slot_q;
  end

  assign bus.chunk_idx   = ctr_q;
  assign bus.chunk_ready = (state_q == FILL);
  assign bus.hv_valid    = (state_q == HOLD);
  assign bus.hv_out      = hv_w;
endmodule

// File: tb/tb_class_hv_assembler.sv
module tb_class_hv_assembler;
  localparam int HV_DIM = 4096;
  localparam int D      = 1024;
  localparam int NC     = HV_DIM / D;

  logic clk   = 1'b0;
  logic nrst  = 1'b1;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  class_hv_assembler_if #(.HV_DIM(HV_DIM), .DIMS_PER_CC(D)) bus ();

  class_hv_assembler #(.HV_DIM(HV_DIM), .DIMS_PER_CC(D)) dut (
    .clk  (clk),
    .nrst (nrst),
    .clear(clear),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Reference: slots hold the latest chunk written to them, m_n counts chunks
  // accepted in the current vector, m_hold marks a complete vector awaiting handover.
  logic [D-1:0] m_slot [NC];
  int m_n = 0;
  bit m_hold = 1'b0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst || clear) begin
      for (int i = 0; i < NC; i++) m_slot[i] <= '0;
      m_n    <= 0;
      m_hold <= 1'b0;
    end else if (m_hold) begin
      if (bus.hv_ready) m_hold <= 1'b0;
    end else if (bus.chunk_valid) begin
      m_slot[m_n] <= bus.chunk_in;
      m_n         <= (m_n + 1) % NC;
      m_hold      <= (m_n == NC - 1);
    end
  end

  function automatic logic [HV_DIM-1:0] m_vec();
    logic [HV_DIM-1:0] v;
    for (int i = 0; i < NC; i++) v[i*D +: D] = m_slot[i];
    return v;
  endfunction

  function automatic logic [D-1:0] rnd_chunk();
    logic [D-1:0] c;
    for (int i = 0; i < D / 32; i++) c[i*32 +: 32] = $urandom;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [HV_DIM-1:0] act,
                     input logic [HV_DIM-1:0] exp);
    int w;
    w = 0;
    n_cmp++;
    if (act !== exp) begin
      for (int i = HV_DIM / 64 - 1; i >= 0; i--)
        if (act[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
      n_err++;
      $display("FAIL %s @%0t: word %0d got %h want %h", nm, $time, w,
               act[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask

  // Cycle-by-cycle check of every output against the reference.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("mdl_ready", HV_DIM'(bus.chunk_ready), HV_DIM'(!m_hold));
      chk("mdl_valid", HV_DIM'(bus.hv_valid),    HV_DIM'(m_hold));
      chk("mdl_idx",   HV_DIM'(bus.chunk_idx),   HV_DIM'(m_n));
      chk("mdl_hv",    bus.hv_out,               m_vec());
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  logic [D-1:0]      g [NC];
  logic [D-1:0]      x;
  logic [HV_DIM-1:0] held;
  logic [HV_DIM-1:0] exp_hv;

  initial begin
    bus.chunk_valid = 1'b0;
    bus.chunk_in    = '0;
    bus.hv_ready    = 1'b0;

    // reset for 3 cycles
    #1 nrst = 1'b0;
    chk_on = 1'b1;
    repeat (3) tick();
    nrst = 1'b1;
    chk("rst_ready", HV_DIM'(bus.chunk_ready), HV_DIM'(1));
    chk("rst_idx",   HV_DIM'(bus.chunk_idx),   HV_DIM'(0));
    chk("rst_valid", HV_DIM'(bus.hv_valid),    HV_DIM'(0));
    chk("rst_hv",    bus.hv_out,               '0);

    // back-to-back fill with hv_ready already high
    bus.hv_ready = 1'b1;
    g[0] = {256{4'h1}}; g[1] = {256{4'hA}}; g[2] = {256{4'h5}}; g[3] = {256{4'hF}};
    for (int k = 0; k < NC; k++) begin
      chk("b2b_idx", HV_DIM'(bus.chunk_idx), HV_DIM'(k));
      bus.chunk_valid = 1'b1;
      bus.chunk_in    = g[k];
      tick();
    end
    bus.chunk_valid = 1'b0;
    chk("b2b_valid", HV_DIM'(bus.hv_valid), HV_DIM'(1));
    chk("b2b_hv", bus.hv_out, {{256{4'hF}}, {256{4'h5}}, {256{4'hA}}, {256{4'h1}}});
    tick();
    chk("b2b_valid_drop", HV_DIM'(bus.hv_valid),    HV_DIM'(0));
    chk("b2b_ready_back", HV_DIM'(bus.chunk_ready), HV_DIM'(1));

    // backpressure: complete vector, then stall 6 cycles with a new chunk offered
    bus.hv_ready = 1'b0;
    for (int k = 0; k < NC; k++) begin
      bus.chunk_valid = 1'b1;
      bus.chunk_in    = rnd_chunk();
      tick();
    end
    x = rnd_chunk();
    bus.chunk_in = x;
    held = bus.hv_out;
    for (int k = 0; k < 6; k++) begin
      chk("bp_valid", HV_DIM'(bus.hv_valid),    HV_DIM'(1));
      chk("bp_ready", HV_DIM'(bus.chunk_ready), HV_DIM'(0));
      chk("bp_hv",    bus.hv_out,               held);
      tick();
    end
    bus.hv_ready = 1'b1;
    tick();
    bus.hv_ready = 1'b0;
    chk("bp_ready_back", HV_DIM'(bus.chunk_ready), HV_DIM'(1));
    chk("bp_idx0",       HV_DIM'(bus.chunk_idx),   HV_DIM'(0));
    tick();
    chk("bp_idx1",  HV_DIM'(bus.chunk_idx), HV_DIM'(1));
    chk("bp_slot0", HV_DIM'(bus.hv_out[D-1:0]), HV_DIM'(x));
    for (int k = 1; k < NC; k++) begin
      bus.chunk_in = rnd_chunk();
      tick();
    end
    bus.chunk_valid = 1'b0;
    bus.hv_ready    = 1'b1;
    tick();
    bus.hv_ready = 1'b0;

    // gapped input: valid every other cycle, 4 accepts span 7 cycles
    for (int k = 0; k < NC; k++) g[k] = rnd_chunk();
    exp_hv = {g[3], g[2], g[1], g[0]};
    for (int k = 0; k < 7; k++) begin
      bus.chunk_valid = (k % 2 == 0);
      bus.chunk_in    = (k % 2 == 0) ? g[k/2] : rnd_chunk();
      tick();
      if (k < 6) begin
        chk("gap_idx",   HV_DIM'(bus.chunk_idx), HV_DIM'((k / 2 + 1) % NC));
        chk("gap_valid", HV_DIM'(bus.hv_valid),  HV_DIM'(0));
      end else begin
        chk("gap_valid_end", HV_DIM'(bus.hv_valid), HV_DIM'(1));
        chk("gap_hv",        bus.hv_out,            exp_hv);
      end
    end
    bus.chunk_valid = 1'b0;
    bus.hv_ready    = 1'b1;
    tick();
    bus.hv_ready = 1'b0;

    // clear mid-vector, with a chunk offered in the same cycle
    for (int k = 0; k < 2; k++) begin
      bus.chunk_valid = 1'b1;
      bus.chunk_in    = rnd_chunk();
      tick();
    end
    chk("clr_pre_idx", HV_DIM'(bus.chunk_idx), HV_DIM'(2));
    clear        = 1'b1;
    bus.chunk_in = rnd_chunk();
    tick();
    clear           = 1'b0;
    bus.chunk_valid = 1'b0;
    chk("clr_idx", HV_DIM'(bus.chunk_idx), HV_DIM'(0));
    chk("clr_hv",  bus.hv_out,             '0);
    tick();
    chk("clr_hv_after", bus.hv_out, '0);

    // asynchronous reset while holding a vector
    for (int k = 0; k < NC; k++) begin
      bus.chunk_valid = 1'b1;
      bus.chunk_in    = rnd_chunk();
      tick();
    end
    bus.chunk_valid = 1'b0;
    chk("ar_valid_pre", HV_DIM'(bus.hv_valid), HV_DIM'(1));
    #1 nrst = 1'b0;
    #1;
    chk("ar_valid", HV_DIM'(bus.hv_valid),    HV_DIM'(0));
    chk("ar_hv",    bus.hv_out,               '0);
    chk("ar_ready", HV_DIM'(bus.chunk_ready), HV_DIM'(1));
    tick();
    nrst = 1'b1;

    // randomized traffic against the reference
    for (int k = 0; k < 600; k++) begin
      bus.chunk_valid = ($urandom_range(0, 9) < 7);
      bus.hv_ready    = ($urandom_range(0, 1) == 1);
      clear           = ($urandom_range(0, 31) == 0);
      bus.chunk_in    = rnd_chunk();
      tick();
    end
    bus.chunk_valid = 1'b0;
    bus.hv_ready    = 1'b0;
    clear           = 1'b0;
    tick();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
